// File: rtl/reqrsp_mem_responder_pkg.sv
// Shared types for the reqrsp memory responder: AMO opcodes, size encoding
// and default request/response structs for the standard 32/64/1 bus shape.
package reqrsp_mem_responder_pkg;

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_e;

    typedef logic [2:0] size_t;

    // q channel payload for a 32-bit address, 64-bit data, 1-bit user bus
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        amo_op_e     amo;
        logic [63:0] data;
        logic [7:0]  strb;
        size_t       size;
        logic [0:0]  user;
    } reqrsp_req_chan_t;

    typedef struct packed {
        reqrsp_req_chan_t q;
        logic             q_valid;
        logic             p_ready;
    } reqrsp_req_t;

    typedef struct packed {
        logic [63:0] data;
        logic        error;
    } reqrsp_rsp_chan_t;

    typedef struct packed {
        reqrsp_rsp_chan_t p;
        logic             p_valid;
        logic             q_ready;
    } reqrsp_rsp_t;

endpackage

// File: rtl/reqrsp_mem_responder_rsp_fifo.sv
// In-order response FIFO with synchronous active-high reset, plus the
// overflow checker that watches it.
module reqrsp_rsp_fifo_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic pop,
    input logic full
);
    // A push into a full FIFO is only legal when a pop frees the slot the same cycle.
    no_overflow_a: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
endmodule

module reqrsp_rsp_fifo #(
    parameter int unsigned Depth = 4,
    parameter type         T     = logic
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  T                             push_data,
    input  logic                         pop,
    output T                             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(Depth+1)-1:0]   count
);
    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned     CntW    = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(32'd1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);
    localparam logic [CntW-1:0] CntOne  = CntW'(32'd1);

    T                storage_r [Depth];
    logic [PtrW-1:0] rd_ptr_r;
    logic [PtrW-1:0] wr_ptr_r;
    logic [CntW-1:0] count_r;
    logic            do_push_s;
    logic            do_pop_s;

    // Pop only real entries; a full FIFO accepts a push only alongside a pop.
    always_comb begin
        do_pop_s  = pop & (count_r != {CntW{1'b0}});
        do_push_s = push & ((count_r != FullCnt) | do_pop_s);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r <= {PtrW{1'b0}};
            wr_ptr_r <= {PtrW{1'b0}};
            count_r  <= {CntW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= (wr_ptr_r == LastPtr) ? {PtrW{1'b0}} : wr_ptr_r + PtrOne;
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == LastPtr) ? {PtrW{1'b0}} : rd_ptr_r + PtrOne;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CntOne;
                2'b01:   count_r <= count_r - CntOne;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents of empty slots are never observed.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            storage_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = storage_r[rd_ptr_r];
    assign empty = (count_r == {CntW{1'b0}});
    assign full  = (count_r == FullCnt);
    assign count = count_r;

    reqrsp_rsp_fifo_chk i_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (do_pop_s),
        .full (full)
    );

endmodule

// File: rtl/reqrsp_mem_responder.sv
// reqrsp responder terminating the bus on a fixed-latency single-port SRAM.
// Credits bound the requests in flight so the response FIFO never overflows;
// responses come back strictly in request order.
module reqrsp_mem_responder
    import reqrsp_mem_responder_pkg::*;
#(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned UserWidth  = 1,
    parameter int unsigned NumWords   = 1024,
    parameter int unsigned MemLatency = 1,
    parameter int unsigned RspDepth   = 4,
    parameter type         req_t      = reqrsp_req_t,
    parameter type         rsp_t      = reqrsp_rsp_t
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  req_t                        slv_req_i,
    output rsp_t                        slv_rsp_o,
    output logic                        mem_req_o,
    output logic [$clog2(NumWords)-1:0] mem_addr_o,
    output logic                        mem_we_o,
    output logic [DataWidth/8-1:0]      mem_be_o,
    output logic [DataWidth-1:0]        mem_wdata_o,
    input  logic [DataWidth-1:0]        mem_rdata_i
);
    localparam int unsigned     ByteOffW    = $clog2(DataWidth / 8);
    localparam int unsigned     WordW       = AddrWidth - ByteOffW;
    localparam int unsigned     MemAddrW    = $clog2(NumWords);
    localparam int unsigned     CntW        = $clog2(RspDepth + 1);
    localparam logic [WordW:0]  NumWordsExt = (WordW + 1)'(NumWords);
    localparam logic [CntW-1:0] CreditsInit = CntW'(RspDepth);
    localparam logic [CntW-1:0] CreditOne  = CntW'(32'd1);

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic                 error;
    } entry_t;

    logic                  ready_en_r;
    logic [CntW-1:0]       credits_r;
    logic                  q_ready_s;
    logic                  accept_s;
    logic [WordW-1:0]      word_s;
    logic                  err_s;
    logic [MemLatency-1:0] pipe_valid_r;
    logic [MemLatency-1:0] pipe_write_r;
    logic [MemLatency-1:0] pipe_err_r;
    logic                  push_s;
    entry_t                push_entry_s;
    logic                  pop_s;
    logic                  p_valid_s;
    entry_t                head_s;
    logic                  full_s;
    logic                  empty_s;
    logic [CntW-1:0]       count_s;
    logic [UserWidth-1:0]  unused_user_s;
    logic                  unused_s;

    assign unused_user_s = slv_req_i.q.user;
    assign unused_s      = ^{slv_req_i.q.size, slv_req_i.q.addr, full_s, count_s, unused_user_s};

    // Handshake and decode: ready comes from credits only, never from q_valid.
    always_comb begin
        q_ready_s = ready_en_r & ~rst_i & (credits_r != {CntW{1'b0}});
        accept_s  = slv_req_i.q_valid & q_ready_s;
        word_s    = slv_req_i.q.addr[AddrWidth-1:ByteOffW];
        err_s     = ({1'b0, word_s} >= NumWordsExt) | (slv_req_i.q.amo != AMONone);
        p_valid_s = ~empty_s & ~rst_i;
        pop_s     = p_valid_s & slv_req_i.p_ready;
    end

    // SRAM strobe: only error-free accepted requests touch the memory.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_addr_o  = {MemAddrW{1'b0}};
        mem_we_o    = 1'b0;
        mem_be_o    = {(DataWidth/8){1'b0}};
        mem_wdata_o = {DataWidth{1'b0}};
        if (accept_s & ~err_s) begin
            mem_req_o   = 1'b1;
            mem_addr_o  = word_s[MemAddrW-1:0];
            mem_we_o    = slv_req_i.q.write;
            mem_be_o    = slv_req_i.q.strb;
            mem_wdata_o = slv_req_i.q.data;
        end else begin
            mem_req_o = 1'b0;
        end
    end

    // Credit counter and post-reset ready enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credits_r  <= CreditsInit;
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            case ({accept_s, pop_s})
                2'b10:   credits_r <= credits_r - CreditOne;
                2'b01:   credits_r <= credits_r + CreditOne;
                default: credits_r <= credits_r;
            endcase
        end
    end

    // Latency-matching shift register tracking each request until its SRAM data arrives.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_valid_r <= {MemLatency{1'b0}};
            pipe_write_r <= {MemLatency{1'b0}};
            pipe_err_r   <= {MemLatency{1'b0}};
        end else begin
            pipe_valid_r[0] <= accept_s;
            pipe_write_r[0] <= slv_req_i.q.write;
            pipe_err_r[0]   <= err_s;
            for (int i = 1; i < int'(MemLatency); i++) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_write_r[i] <= pipe_write_r[i-1];
                pipe_err_r[i]   <= pipe_err_r[i-1];
            end
        end
    end

    // Build the FIFO entry for the request leaving the pipeline this cycle.
    always_comb begin
        push_s             = pipe_valid_r[MemLatency-1];
        push_entry_s.data  = {DataWidth{1'b0}};
        push_entry_s.error = 1'b0;
        if (pipe_err_r[MemLatency-1]) begin
            push_entry_s.error = 1'b1;
        end else if (pipe_write_r[MemLatency-1]) begin
            push_entry_s.data = {DataWidth{1'b0}};
        end else begin
            push_entry_s.data = mem_rdata_i;
        end
    end

    reqrsp_rsp_fifo #(
        .Depth (RspDepth),
        .T     (entry_t)
    ) i_rsp_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .count     (count_s)
    );

    // Response channel: payload is forced to zero whenever nothing is presented.
    always_comb begin
        slv_rsp_o         = {$bits(rsp_t){1'b0}};
        slv_rsp_o.q_ready = q_ready_s;
        slv_rsp_o.p_valid = p_valid_s;
        if (p_valid_s) begin
            slv_rsp_o.p.data  = head_s.data;
            slv_rsp_o.p.error = head_s.error;
        end else begin
            slv_rsp_o.p.data  = {DataWidth{1'b0}};
            slv_rsp_o.p.error = 1'b0;
        end
    end

endmodule
